// File: rtl/hoist_pkg.sv
// rtl/hoist_pkg.sv - hoist mode/action codes shared with the seven-segment coders
package hoist_pkg;

  localparam int MODE_W   = 2;
  localparam int ACTION_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_STOP = 2'd0,
    MODE_PICK = 2'd1,
    MODE_DROP = 2'd2,
    MODE_PARK = 2'd3
  } hoist_mode_e;

  // State codes double as the action value driven to the display coder.
  typedef enum logic [ACTION_W-1:0] {
    ST_IDLE        = 3'd0,
    ST_DOWN        = 3'd1,
    ST_UP          = 3'd2,
    ST_WAIT_HOOK   = 3'd3,
    ST_WAIT_UNHOOK = 3'd4,
    ST_FAULT       = 3'd5
  } hoist_state_e;

  function automatic logic is_busy(input hoist_state_e s);
    return (s != ST_IDLE) && (s != ST_FAULT);
  endfunction

endpackage

// File: rtl/hoist_tick.sv
// rtl/hoist_tick.sv - free-running motion tick prescaler, one pulse every DIV clocks
module hoist_tick #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/hoist_ctrl.sv
// rtl/hoist_ctrl.sv - hook-hoist command FSM with height counter and hook-wait timeout
module hoist_ctrl
  import hoist_pkg::*;
#(
  parameter int DIV      = 50_000_000,
  parameter int HEIGHT_W = 3,
  parameter int MAX_H    = 7,
  parameter int HOOK_TO  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_mode,
  input  logic [MODE_W-1:0]   mode_in,
  input  logic [HEIGHT_W-1:0] target_in,
  input  logic                hooked,
  input  logic                unhooked,
  output logic [MODE_W-1:0]   mode_out,
  output logic [ACTION_W-1:0] action,
  output logic [HEIGHT_W-1:0] height,
  output logic                busy,
  output logic                done
);

  localparam logic [HEIGHT_W-1:0] TOP = HEIGHT_W'(MAX_H);
  localparam int TW = $clog2(HOOK_TO + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(HOOK_TO - 1);

  logic                tick;
  hoist_state_e        state_q, state_d;
  hoist_mode_e         mode_q, mode_d, cmd;
  logic [HEIGHT_W-1:0] tgt_q, tgt_d, h_q, h_d, goal;
  logic [TW-1:0]       to_q, to_d;
  logic                done_d, wait_met;

  hoist_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign cmd = hoist_mode_e'(mode_in);

  // Goal height of the current motion phase, derived from the latched command.
  always_comb begin
    goal = TOP;
    if (state_q == ST_DOWN) begin
      goal = (mode_q == MODE_PICK) ? '0 : tgt_q;
    end else if (state_q == ST_UP && mode_q == MODE_PICK) begin
      goal = tgt_q;
    end
  end

  assign wait_met = (state_q == ST_WAIT_HOOK) ? (hooked && !unhooked)
                                              : (unhooked && !hooked);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tgt_d   = tgt_q;
    h_d     = h_q;
    to_d    = to_q;
    done_d  = 1'b0;
    if (write_mode && (cmd == MODE_STOP || state_q == ST_FAULT)) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      if (write_mode) begin
        mode_d  = cmd;
        tgt_d   = (target_in > TOP) ? TOP : target_in;
        state_d = (cmd == MODE_PARK) ? ST_UP : ST_DOWN;
      end
    end else if (tick) begin
      case (state_q)
        ST_DOWN: begin
          if (h_q > goal) begin
            h_d = h_q - 1'b1;
          end else begin
            state_d = (mode_q == MODE_PICK) ? ST_WAIT_HOOK : ST_WAIT_UNHOOK;
            to_d    = '0;
          end
        end
        ST_UP: begin
          if (h_q < goal) begin
            h_d = h_q + 1'b1;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        ST_WAIT_HOOK, ST_WAIT_UNHOOK: begin
          if (wait_met) begin
            state_d = ST_UP;
          end else if (to_q == TO_LAST) begin
            state_d = ST_FAULT;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_STOP;
      tgt_q   <= TOP;
      h_q     <= TOP;
      to_q    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tgt_q   <= tgt_d;
      h_q     <= h_d;
      to_q    <= to_d;
      busy    <= is_busy(state_d);
      done    <= done_d;
    end
  end

  assign mode_out = mode_q;
  assign action   = state_q;
  assign height   = h_q;

endmodule

// File: tb/tb_hoist_ctrl.sv
// tb/tb_hoist_ctrl.sv - directed-vector bench for hoist_ctrl (park heights 7 and 5)
module tb_hoist_ctrl;

  localparam int A_IDLE = 0, A_DOWN = 1, A_UP = 2, A_WHOOK = 3, A_WUNHOOK = 4, A_FAULT = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write_mode = 1'b0, hooked = 1'b0, unhooked = 1'b0;
  logic [1:0] mode_in = 2'd0;
  logic [2:0] target_in = 3'd0;
  logic [1:0] mode_out;
  logic [2:0] action, height;
  logic       busy, done;

  logic       wm5 = 1'b0, hooked5 = 1'b0, unhooked5 = 1'b0;
  logic [1:0] mode5 = 2'd0;
  logic [2:0] tgt5 = 3'd0;
  logic [1:0] mode_out5;
  logic [2:0] action5, height5;
  logic       busy5, done5;

  int vectors = 0, miscompares = 0, done_cnt = 0;

  always #5 clk = ~clk;

  hoist_ctrl #(.DIV(1), .HEIGHT_W(3), .MAX_H(7), .HOOK_TO(8)) u_dut (
    .clk(clk), .reset(reset), .write_mode(write_mode), .mode_in(mode_in),
    .target_in(target_in), .hooked(hooked), .unhooked(unhooked),
    .mode_out(mode_out), .action(action), .height(height), .busy(busy), .done(done)
  );

  hoist_ctrl #(.DIV(1), .HEIGHT_W(3), .MAX_H(5), .HOOK_TO(8)) u_dut5 (
    .clk(clk), .reset(reset), .write_mode(wm5), .mode_in(mode5),
    .target_in(tgt5), .hooked(hooked5), .unhooked(unhooked5),
    .mode_out(mode_out5), .action(action5), .height(height5), .busy(busy5), .done(done5)
  );

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] m, input logic [2:0] t);
    write_mode = 1'b1;
    mode_in    = m;
    target_in  = t;
    cyc();
    write_mode = 1'b0;
  endtask

  task automatic expect_st(input string tag, input int a, input int h);
    chk({tag, ":action"}, 32'(action), a);
    chk({tag, ":height"}, 32'(height), h);
  endtask

  initial begin
    #12;
    expect_st("reset", A_IDLE, 7);
    chk("reset:mode", 32'(mode_out), 0);
    chk("reset:busy", 32'(busy), 0);
    chk("reset:done", 32'(done), 0);
    chk("reset5:height", 32'(height5), 5);
    reset = 1'b1;
    cyc();
    expect_st("post_reset", A_IDLE, 7);

    // PICK to 5, hook arrives after 3 waiting ticks
    cmd(2'd1, 3'd5);
    expect_st("pick_accept", A_DOWN, 7);
    chk("pick_busy", 32'(busy), 1);
    chk("pick_mode", 32'(mode_out), 1);
    for (int h = 6; h >= 0; h--) begin cyc(); expect_st("pick_down", A_DOWN, h); end
    cyc(); expect_st("pick_whook", A_WHOOK, 0);
    repeat (3) begin cyc(); expect_st("pick_whook_wait", A_WHOOK, 0); end
    hooked = 1'b1;
    cyc(); expect_st("pick_hooked", A_UP, 0);
    hooked = 1'b0;
    for (int h = 1; h <= 5; h++) begin
      cyc(); expect_st("pick_up", A_UP, h); chk("pick_nodone", 32'(done), 0);
    end
    cyc(); expect_st("pick_end", A_IDLE, 5);
    chk("pick_done", 32'(done), 1);
    chk("pick_busy_end", 32'(busy), 0);
    cyc(); chk("pick_done_pulse", 32'(done), 0);
    chk("pick_done_cnt", 32'(done_cnt), 1);

    // DROP to 2, unhook never comes -> timeout fault, then clear
    cmd(2'd2, 3'd2);
    expect_st("drop_accept", A_DOWN, 5);
    chk("drop_mode", 32'(mode_out), 2);
    for (int h = 4; h >= 2; h--) begin cyc(); expect_st("drop_down", A_DOWN, h); end
    cyc(); expect_st("drop_wunhook", A_WUNHOOK, 2);
    repeat (7) begin cyc(); expect_st("drop_wait", A_WUNHOOK, 2); end
    cyc(); expect_st("drop_fault", A_FAULT, 2);
    chk("drop_fault_busy", 32'(busy), 0);
    chk("drop_fault_done", 32'(done), 0);
    repeat (2) begin cyc(); expect_st("drop_fault_sticky", A_FAULT, 2); end
    cmd(2'd0, 3'd0);
    expect_st("drop_clear", A_IDLE, 2);
    chk("drop_done_cnt", 32'(done_cnt), 1);

    // PARK from 2, then PARK from top (phase skipped)
    cmd(2'd3, 3'd0);
    expect_st("park2_accept", A_UP, 2);
    for (int h = 3; h <= 7; h++) begin cyc(); expect_st("park2_up", A_UP, h); end
    cyc(); expect_st("park2_end", A_IDLE, 7); chk("park2_done", 32'(done), 1);
    cmd(2'd3, 3'd0);
    expect_st("park7_accept", A_UP, 7);
    cyc(); expect_st("park7_end", A_IDLE, 7); chk("park7_done", 32'(done), 1);

    // DROP to 6, both sensors high does not release the wait
    cmd(2'd2, 3'd6);
    expect_st("drop6_accept", A_DOWN, 7);
    cyc(); expect_st("drop6_down", A_DOWN, 6);
    cyc(); expect_st("drop6_wunhook", A_WUNHOOK, 6);
    hooked = 1'b1; unhooked = 1'b1;
    cyc(); expect_st("drop6_both", A_WUNHOOK, 6);
    hooked = 1'b0;
    cyc(); expect_st("drop6_unhooked", A_UP, 6);
    unhooked = 1'b0;
    cyc(); expect_st("drop6_up", A_UP, 7);
    cyc(); expect_st("drop6_end", A_IDLE, 7); chk("drop6_done", 32'(done), 1);

    // PICK interrupted: busy strobe ignored, then abort at 4
    cmd(2'd1, 3'd1);
    cyc(); expect_st("abort_down", A_DOWN, 6);
    cyc(); expect_st("abort_down", A_DOWN, 5);
    write_mode = 1'b1; mode_in = 2'd2; target_in = 3'd1;
    cyc(); expect_st("busy_ignore", A_DOWN, 4);
    chk("busy_ignore_mode", 32'(mode_out), 1);
    mode_in = 2'd0;
    cyc(); write_mode = 1'b0;
    expect_st("abort", A_IDLE, 4);
    chk("abort_done", 32'(done), 0);
    chk("abort_busy", 32'(busy), 0);
    cyc(); expect_st("abort_hold", A_IDLE, 4); chk("abort_nodone", 32'(done), 0);

    // reach 3 via an aborted DROP, then PARK from 3
    cmd(2'd2, 3'd3);
    cyc(); expect_st("drop3_down", A_DOWN, 3);
    cyc(); expect_st("drop3_wait", A_WUNHOOK, 3);
    cmd(2'd0, 3'd0); expect_st("drop3_abort", A_IDLE, 3);
    cmd(2'd3, 3'd0); expect_st("park3_accept", A_UP, 3);
    for (int h = 4; h <= 7; h++) begin cyc(); expect_st("park3_up", A_UP, h); end
    cyc(); expect_st("park3_end", A_IDLE, 7); chk("park3_done", 32'(done), 1);
    cyc(); chk("done_total", 32'(done_cnt), 5);

    // sensor fault in WAIT_HOOK times out; non-STOP strobe only clears FAULT
    cmd(2'd1, 3'd1);
    for (int h = 6; h >= 0; h--) begin cyc(); expect_st("sf_down", A_DOWN, h); end
    cyc(); expect_st("sf_whook", A_WHOOK, 0);
    hooked = 1'b1; unhooked = 1'b1;
    repeat (7) begin cyc(); expect_st("sf_wait", A_WHOOK, 0); end
    cyc(); expect_st("sf_fault", A_FAULT, 0); chk("sf_busy", 32'(busy), 0);
    write_mode = 1'b1; mode_in = 2'd1;
    cyc(); write_mode = 1'b0;
    expect_st("sf_clear", A_IDLE, 0);
    hooked = 1'b0; unhooked = 1'b0;
    cyc(); expect_st("sf_not_started", A_IDLE, 0); chk("sf_busy_clear", 32'(busy), 0);
    chk("sf_done_cnt", 32'(done_cnt), 5);

    // MAX_H=5 build: target 7 clamps to 5
    wm5 = 1'b1; mode5 = 2'd1; tgt5 = 3'd7;
    cyc(); wm5 = 1'b0;
    chk("clamp_accept", 32'(action5), A_DOWN);
    for (int h = 4; h >= 0; h--) begin cyc(); chk("clamp_down", 32'(height5), h); end
    cyc(); chk("clamp_whook", 32'(action5), A_WHOOK);
    hooked5 = 1'b1;
    cyc(); chk("clamp_hooked", 32'(action5), A_UP);
    hooked5 = 1'b0;
    for (int h = 1; h <= 5; h++) begin cyc(); chk("clamp_up", 32'(height5), h); end
    cyc(); chk("clamp_end", 32'(action5), A_IDLE);
    chk("clamp_height", 32'(height5), 5);
    chk("clamp_done", 32'(done5), 1);

    // asynchronous reset in the middle of a DOWN phase
    cmd(2'd3, 3'd0);
    for (int h = 1; h <= 7; h++) begin cyc(); expect_st("rst_park", A_UP, h); end
    cyc(); expect_st("rst_park_end", A_IDLE, 7);
    cmd(2'd1, 3'd0);
    for (int h = 6; h >= 3; h--) begin cyc(); expect_st("rst_down", A_DOWN, h); end
    #2; reset = 1'b0; #1;
    expect_st("async_reset", A_IDLE, 7);
    chk("async_reset_mode", 32'(mode_out), 0);
    chk("async_reset_busy", 32'(busy), 0);
    chk("async_reset_done", 32'(done), 0);
    cyc(); reset = 1'b1;
    cyc(); expect_st("reset_release", A_IDLE, 7);
    chk("reset_release_mode", 32'(mode_out), 0);
    chk("reset_release_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
